uart_mmio: RTL

//  Memory-mapped UART peripheral, next generation of the controller's UART: word-wide DATA

---
 rtl/uart_mmio_pkg.sv | 22 ++
 rtl/uart_mmio_fifo.sv | 46 ++++
 rtl/uart_tool.sv | 98 +++++++++
 rtl/uart_mmio.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, CTRL bit indices
// and the bus FSM state encoding.
package uart_mmio_pkg;
  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_CTRL    = 3'd2;
  localparam logic [2:0] REG_TIMEOUT = 3'd3;

  localparam int CTRL_BE      = 0;
  localparam int CTRL_IRQ_RX  = 1;
  localparam int CTRL_IRQ_TXE = 2;
  localparam int CTRL_CLR_OVR = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REG  = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REG  = 3'd3,
    S_WR_DATA = 3'd4,
    S_RESP    = 3'd5
  } state_t;
endpackage

// File: rtl/uart_mmio_fifo.sv
// Synchronous FIFO with occupancy count; a pop frees the slot for a same-cycle push.
module uart_mmio_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rp];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end
endmodule

// File: rtl/uart_tool.sv
// 8N1 serial receiver and transmitter; CLK_FREQ/BIT_RATE clock cycles per bit.
module uart_tool_rx #(
  parameter int CLK_FREQ     = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_rxd,
  output logic                    o_valid,
  output logic [PAYLOAD_BITS-1:0] o_data
);
  localparam int CPB = CLK_FREQ / BIT_RATE;
  localparam int CW  = $clog2(CPB + 1);
  logic [1:0]              r_sync;
  logic                    r_busy;
  logic [CW-1:0]           r_cyc;
  logic [3:0]              r_bit;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic                    r_valid;

  assign o_valid = r_valid;
  assign o_data  = r_shift;

  // Bit 0 is the start bit sampled mid-period; a high sample there is a glitch, not a frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= 2'b11; r_busy <= 1'b0; r_cyc <= '0;
      r_bit  <= '0;    r_shift <= '0;  r_valid <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rxd};
      r_valid <= 1'b0;
      if (!r_busy) begin
        if (!r_sync[1]) begin
          r_busy <= 1'b1;
          r_cyc  <= CW'(CPB / 2 - 1);
          r_bit  <= '0;
        end
      end else if (r_cyc != '0) begin
        r_cyc <= r_cyc - 1'b1;
      end else begin
        r_cyc <= CW'(CPB - 1);
        r_bit <= r_bit + 1'b1;
        if (r_bit == 4'd0 && r_sync[1]) begin
          r_busy <= 1'b0;
        end else if (r_bit == 4'(PAYLOAD_BITS + 1)) begin
          r_busy  <= 1'b0;
          r_valid <= r_sync[1];
        end else if (r_bit != 4'd0) begin
          r_shift <= {r_sync[1], r_shift[PAYLOAD_BITS-1:1]};
        end
      end
    end
  end
endmodule

module uart_tool_tx #(
  parameter int CLK_FREQ     = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_en,
  input  logic [PAYLOAD_BITS-1:0] i_data,
  output logic                    o_txd,
  output logic                    o_busy
);
  localparam int CPB = CLK_FREQ / BIT_RATE;
  localparam int CW  = $clog2(CPB + 1);
  logic                    r_busy;
  logic [CW-1:0]           r_cyc;
  logic [3:0]              r_bit;
  logic [PAYLOAD_BITS+1:0] r_shift;

  assign o_busy = r_busy;
  assign o_txd  = r_busy ? r_shift[0] : 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy <= 1'b0; r_cyc <= '0; r_bit <= '0; r_shift <= '1;
    end else if (!r_busy) begin
      if (i_en) begin
        r_shift <= {1'b1, i_data, 1'b0};
        r_busy  <= 1'b1;
        r_cyc   <= '0;
        r_bit   <= '0;
      end
    end else if (r_cyc == CW'(CPB - 1)) begin
      r_cyc   <= '0;
      r_shift <= {1'b1, r_shift[PAYLOAD_BITS+1:1]};
      if (r_bit == 4'(PAYLOAD_BITS + 1)) r_busy <= 1'b0;
      else r_bit <= r_bit + 1'b1;
    end else begin
      r_cyc <= r_cyc + 1'b1;
    end
  end
endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: word-wide DATA access through RX/TX FIFOs, byte-order select,
// per-access timeout, status/ctrl registers and a level interrupt.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int          CLK_FREQ       = 25000000,
  parameter int          BIT_RATE       = 9600,
  parameter int          PAYLOAD_BITS   = 8,
  parameter int          BUFFER_SIZE    = 16,
  parameter int          WORD_BYTES     = 4,
  parameter logic [15:0] TIMEOUT_RST    = 16'd0,
  parameter logic        BIG_ENDIAN_RST = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx,
  output logic        tx,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        response,
  output logic        error,
  output logic        irq,
  output state_t      dbg_state
);
  localparam int CW = $clog2(BUFFER_SIZE) + 1;

  // Bus protocol: read/write are sampled only in IDLE (write wins); exactly one
  // response pulse follows each accepted request, with error and read_data valid alongside.
  state_t      r_state, w_next;
  logic [2:0]  r_addr;
  logic [1:0]  r_idx;
  logic [1:0]  w_lane;
  logic [15:0] r_tmo_cnt, r_timeout;
  logic [2:0]  r_ctrl;
  logic [31:0] r_wdata, r_read_data, w_reg_rdata;
  logic        r_ovr, r_error, r_irq;
  logic        w_rx_pop, w_tx_push, w_moved, w_tmo_hit, w_tmo_reached, w_last;
  logic        w_rx_valid, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty, w_tx_busy, w_tx_pop;
  logic        w_ovr_clr;
  logic [PAYLOAD_BITS-1:0] w_rx_byte, w_rx_data, w_tx_data;
  logic [CW-1:0] w_rx_count, w_tx_count;
  logic        w_unused;

  assign w_unused  = ^{address[31:5], address[1:0]};
  assign read_data = r_read_data;
  assign response  = (r_state == S_RESP);
  assign error     = r_error;
  assign irq       = r_irq;
  assign dbg_state = r_state;

  // Byte k of the word travels through lane k (little-endian) or lane WORD_BYTES-1-k.
  assign w_lane        = r_ctrl[CTRL_BE] ? 2'(WORD_BYTES - 1) - r_idx : r_idx;
  assign w_last        = (r_idx == 2'(WORD_BYTES - 1));
  assign w_tmo_reached = (r_timeout != '0) && ({1'b0, r_tmo_cnt} + 17'd1 == {1'b0, r_timeout});
  assign w_tx_pop      = ~w_tx_busy & ~w_tx_empty;
  assign w_ovr_clr     = (r_state == S_WR_REG) && (r_addr == REG_CTRL) && write_data[CTRL_CLR_OVR];

  uart_tool_rx #(.CLK_FREQ(CLK_FREQ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PAYLOAD_BITS)) u_rx (
    .clk(clk), .resetn(resetn), .i_rxd(rx), .o_valid(w_rx_valid), .o_data(w_rx_byte));

  uart_tool_tx #(.CLK_FREQ(CLK_FREQ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PAYLOAD_BITS)) u_tx (
    .clk(clk), .resetn(resetn), .i_en(w_tx_pop), .i_data(w_tx_data), .o_txd(tx), .o_busy(w_tx_busy));

  uart_mmio_fifo #(.W(PAYLOAD_BITS), .DEPTH(BUFFER_SIZE)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .i_push(w_rx_valid), .i_data(w_rx_byte), .i_pop(w_rx_pop),
    .o_data(w_rx_data), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count));

  uart_mmio_fifo #(.W(PAYLOAD_BITS), .DEPTH(BUFFER_SIZE)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .i_push(w_tx_push), .i_data(r_wdata[{w_lane, 3'b000} +: 8]),
    .i_pop(w_tx_pop), .o_data(w_tx_data), .o_full(w_tx_full), .o_empty(w_tx_empty),
    .o_count(w_tx_count));

  always_comb begin
    w_reg_rdata = '0;
    case (r_addr)
      REG_STATUS:  w_reg_rdata = {16'(w_rx_count), 12'(w_tx_count), r_ovr, w_tx_full,
                                  w_rx_empty, w_tx_empty};
      REG_CTRL:    w_reg_rdata = {29'd0, r_ctrl};
      REG_TIMEOUT: w_reg_rdata = {16'd0, r_timeout};
      default:     w_reg_rdata = '0;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_rx_pop  = 1'b0;
    w_tx_push = 1'b0;
    w_moved   = 1'b0;
    w_tmo_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (write)     w_next = S_WR_REG;
        else if (read) w_next = S_RD_REG;
      end
      S_RD_REG: w_next = (r_addr == REG_DATA) ? S_RD_DATA : S_RESP;
      S_WR_REG: w_next = (r_addr == REG_DATA) ? S_WR_DATA : S_RESP;
      S_RD_DATA: begin
        if (!w_rx_empty) begin
          w_rx_pop = 1'b1;
          w_moved  = 1'b1;
          if (w_last) w_next = S_RESP;
        end else if (w_tmo_reached) begin
          w_tmo_hit = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_WR_DATA: begin
        if (!w_tx_full) begin
          w_tx_push = 1'b1;
          w_moved   = 1'b1;
          if (w_last) w_next = S_RESP;
        end else if (w_tmo_reached) begin
          w_tmo_hit = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_idx       <= '0;
      r_tmo_cnt   <= '0;
      r_timeout   <= TIMEOUT_RST;
      r_ctrl      <= {2'b00, BIG_ENDIAN_RST};
      r_wdata     <= '0;
      r_read_data <= '0;
      r_ovr       <= 1'b0;
      r_error     <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_error <= w_tmo_hit;
      r_irq   <= (r_ctrl[CTRL_IRQ_RX] & ~w_rx_empty) | (r_ctrl[CTRL_IRQ_TXE] & w_tx_empty);
      r_ovr   <= (w_rx_valid & w_rx_full & ~w_rx_pop) | (r_ovr & ~w_ovr_clr);
      if (r_state == S_IDLE) begin
        r_addr    <= address[4:2];
        r_idx     <= '0;
        r_tmo_cnt <= '0;
      end
      if (r_state == S_RD_REG) r_read_data <= w_reg_rdata;
      if (r_state == S_WR_REG) begin
        r_wdata <= write_data;
        if (r_addr == REG_CTRL)    r_ctrl    <= write_data[2:0];
        if (r_addr == REG_TIMEOUT) r_timeout <= write_data[15:0];
      end
      if (w_rx_pop) r_read_data[{w_lane, 3'b000} +: 8] <= w_rx_data[7:0];
      if (w_moved) begin
        r_idx     <= r_idx + 1'b1;
        r_tmo_cnt <= '0;
      end else if (r_state == S_RD_DATA || r_state == S_WR_DATA) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end
endmodule
